regfile_wb_scheduler: RTL and testbench

- Write-back scheduler and scoreboard for the 32x64 register file.
- Shares the register file's single write port (RW/BusW/RegWr) between the ALU and memory write-back requesters using round-robin arbitration.
- Tracks outstanding writes per destination register and raises read stalls for the RA/RB operands.
- Sits between the execute/memory stages and the register file; the register file commits on negedge Clk, this block drives the port from posedge flops.

---
 rtl/regfile_wb_scheduler_pkg.sv | 7 +
 rtl/regfile_wb_scheduler_if.sv | 15 +
 rtl/regfile_wb_scheduler_wb_scoreboard.sv | 51 +++++
 rtl/regfile_wb_scheduler.sv | 55 +++++
 tb/tb_regfile_wb_scheduler.sv | 132 +++++++++++++
 5 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared indices and requester encoding for the write-back scheduler
package regfile_wb_scheduler_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;
  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_e;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: requester, issue, read-operand and register-file write-port signals
interface regfile_wb_scheduler_if #(parameter int DATA_W = 64);
  logic              AluValid, AluReady, MemValid, MemReady;
  logic [4:0]        AluRd, MemRd, IssueRd, RA, RB, RW;
  logic [DATA_W-1:0] AluData, MemData, BusW;
  logic              IssueValid, IssueReady, StallA, StallB, RegWr, WbErr;
  modport master (
    output AluValid, AluRd, AluData, MemValid, MemRd, MemData, IssueValid, IssueRd, RA, RB,
    input  AluReady, MemReady, IssueReady, StallA, StallB, RW, BusW, RegWr, WbErr
  );
  modport slave (
    input  AluValid, AluRd, AluData, MemValid, MemRd, MemData, IssueValid, IssueRd, RA, RB,
    output AluReady, MemReady, IssueReady, StallA, StallB, RW, BusW, RegWr, WbErr
  );
endinterface

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// wb_scoreboard: per-register outstanding-write counters, issue back-pressure and read stalls
module wb_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int ZERO_IDX = ZERO_REG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [REG_IDX_W-1:0] ra,
  input  logic [REG_IDX_W-1:0] rb,
  output logic                 issue_ready,
  output logic                 stall_a,
  output logic                 stall_b,
  output logic                 wb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [REG_IDX_W-1:0] ZR = REG_IDX_W'(ZERO_IDX);
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v, dec_v;
  logic inc_any, dec_any, wb_err_q, wb_err_d;
  always_comb begin
    issue_ready = cnt_q[issue_rd] != CNT_MAX;
    inc_any = issue_valid && issue_ready && issue_rd != ZR;
    dec_any = wb_valid && wb_rd != ZR;
    inc_v = inc_any ? NUM_REGS'(1) << issue_rd : '0;
    dec_v = dec_any ? NUM_REGS'(1) << wb_rd : '0;
    wb_err_d = wb_err_q || (dec_any && cnt_q[wb_rd] == '0);
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d[i] = (inc_v[i] && !dec_v[i]) ? cnt_q[i] + CNT_W'(1) :
                 (dec_v[i] && !inc_v[i] && cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
    cnt_d[ZERO_IDX] = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
      wb_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end
  assign stall_a = ra != ZR && cnt_q[ra] != '0;
  assign stall_b = rb != ZR && cnt_q[rb] != '0;
  assign wb_err = wb_err_q;
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin ALU/MEM arbitration onto the register-file write port
// with a scoreboard of outstanding writes driving read stalls and issue back-pressure.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W = 2,
  parameter int ZERO_IDX = ZERO_REG
) (
  input logic Clk,
  input logic Reset_n,
  regfile_wb_scheduler_if.slave bus
);
  localparam logic [REG_IDX_W-1:0] ZR = REG_IDX_W'(ZERO_IDX);
  req_e last_q, last_d;
  logic alu_gnt, mem_gnt, wb_valid, wr_en, regwr_q, regwr_d;
  logic [REG_IDX_W-1:0] wb_rd, rw_q, rw_d;
  logic [DATA_W-1:0] wb_data, busw_q, busw_d;
  always_comb begin
    alu_gnt = bus.AluValid && (!bus.MemValid || last_q == REQ_MEM);
    mem_gnt = bus.MemValid && !alu_gnt;
    wb_valid = alu_gnt || mem_gnt;
    wb_rd = alu_gnt ? bus.AluRd : bus.MemRd;
    wb_data = alu_gnt ? bus.AluData : bus.MemData;
    wr_en = wb_valid && wb_rd != ZR;
    last_d = (bus.AluValid && bus.MemValid) ? (alu_gnt ? REQ_ALU : REQ_MEM) : last_q;
    regwr_d = wr_en;
    rw_d = wr_en ? wb_rd : rw_q;
    busw_d = wr_en ? wb_data : busw_q;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      last_q <= REQ_MEM;
      regwr_q <= 1'b0;
      rw_q <= '0;
      busw_q <= '0;
    end else begin
      last_q <= last_d;
      regwr_q <= regwr_d;
      rw_q <= rw_d;
      busw_q <= busw_d;
    end
  end
  wb_scoreboard #(.CNT_W(CNT_W), .ZERO_IDX(ZERO_IDX)) u_sb (
    .clk(Clk), .rst_n(Reset_n),
    .issue_valid(bus.IssueValid), .issue_rd(bus.IssueRd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .ra(bus.RA), .rb(bus.RB),
    .issue_ready(bus.IssueReady), .stall_a(bus.StallA), .stall_b(bus.StallB), .wb_err(bus.WbErr)
  );
  assign bus.AluReady = alu_gnt;
  assign bus.MemReady = mem_gnt;
  assign bus.RegWr = regwr_q;
  assign bus.RW = rw_q;
  assign bus.BusW = busw_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed plan plus random traffic against a per-register pending-count model
module tb_regfile_wb_scheduler;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  regfile_wb_scheduler_if #(.DATA_W(64)) bus();
  regfile_wb_scheduler #(.DATA_W(64), .CNT_W(2), .ZERO_IDX(31)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  int pend [32];
  bit err, last_was_mem, exp_wr, alu_lost, mem_lost;
  logic [4:0] exp_rw;
  logic [63:0] exp_busw;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit av, input int ard, input logic [63:0] ad, input bit mv, input int mrd,
                       input logic [63:0] md, input bit iv, input int ird, input int ra, input int rb, input bit rn);
    bus.AluValid = av; bus.AluRd = 5'(ard); bus.AluData = ad;
    bus.MemValid = mv; bus.MemRd = 5'(mrd); bus.MemData = md;
    bus.IssueValid = iv; bus.IssueRd = 5'(ird); bus.RA = 5'(ra); bus.RB = 5'(rb);
    Reset_n = rn;
  endtask
  task automatic cycle();
    bit ag, mg, take_issue, wb;
    int rd, ird;
    logic [63:0] d;
    #2;
    ag = bus.AluValid && (!bus.MemValid || last_was_mem);
    mg = bus.MemValid && !ag;
    ird = int'(bus.IssueRd);
    chk("alu_ready", bus.AluReady, ag);
    chk("mem_ready", bus.MemReady, mg);
    chk("issue_ready", bus.IssueReady, pend[ird] < 3);
    chk("stall_a", bus.StallA, bus.RA != 31 && pend[bus.RA] > 0);
    chk("stall_b", bus.StallB, bus.RB != 31 && pend[bus.RB] > 0);
    @(posedge Clk);
    if (!Reset_n) begin
      foreach (pend[i]) pend[i] = 0;
      err = 0; last_was_mem = 1; exp_wr = 0; exp_rw = 0; exp_busw = 0;
      alu_lost = 0; mem_lost = 0;
    end else begin
      alu_lost = bus.AluValid && !ag;
      mem_lost = bus.MemValid && !mg;
      if (bus.AluValid && bus.MemValid) last_was_mem = mg;
      rd = ag ? int'(bus.AluRd) : int'(bus.MemRd);
      d = ag ? bus.AluData : bus.MemData;
      wb = (ag || mg) && rd != 31;
      take_issue = bus.IssueValid && pend[ird] < 3 && ird != 31;
      exp_wr = wb;
      if (wb) begin exp_rw = 5'(rd); exp_busw = d; end
      if (wb && pend[rd] == 0) err = 1;
      if (!(take_issue && wb && ird == rd)) begin
        if (take_issue) pend[ird] = pend[ird] + 1;
        if (wb && pend[rd] > 0) pend[rd] = pend[rd] - 1;
      end
    end
    #1;
    chk("reg_wr", bus.RegWr, exp_wr);
    chk("rw", bus.RW, exp_rw);
    chk("busw", bus.BusW, exp_busw);
    chk("wb_err", bus.WbErr, err);
  endtask
  initial begin
    logic [4:0] a_rd, m_rd;
    logic [63:0] a_d, m_d;
    bit a_v, m_v;
    foreach (pend[i]) pend[i] = 0;
    last_was_mem = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 1);
    #2;
    chk("rst_regwr", bus.RegWr, 0);
    chk("rst_issue_ready", bus.IssueReady, 1);
    chk("rst_stall", {bus.StallA, bus.StallB}, 0);
    chk("rst_wberr", bus.WbErr, 0);
    #0 cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1); #2 chk("stall_a_set", bus.StallA, 1); cycle();
    drive(1, 5, 64'hDEAD, 0, 0, 0, 0, 0, 5, 0, 1); cycle();
    chk("dead_rw", bus.RW, 5); chk("dead_busw", bus.BusW, 64'hDEAD);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1); #2 chk("stall_a_clr", bus.StallA, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 4, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 4, 3, 4, 1); cycle();
    drive(1, 3, 64'h33, 1, 4, 64'h44, 0, 0, 3, 4, 1); #2 chk("conflict1_alu", bus.AluReady, 1); cycle();
    chk("conflict1_rw", bus.RW, 3);
    drive(0, 3, 64'h33, 1, 4, 64'h44, 0, 0, 3, 4, 1); cycle();
    chk("conflict2_rw", bus.RW, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 1); cycle();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 1); cycle(); end
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 1); #2 chk("sat_issue_ready", bus.IssueReady, 0); cycle();
    drive(1, 7, 64'h77, 0, 0, 0, 0, 0, 7, 0, 1); cycle();
    drive(1, 7, 64'h78, 0, 0, 0, 1, 7, 7, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 1); #2 chk("resat_issue_ready", bus.IssueReady, 0); cycle();
    drive(0, 0, 0, 1, 31, 64'h1F, 0, 0, 0, 0, 1); #2 chk("zero_ready", bus.MemReady, 1); cycle();
    chk("zero_regwr", bus.RegWr, 0);
    drive(0, 0, 0, 1, 9, 64'h99, 0, 0, 0, 0, 1); cycle();
    chk("wberr_set", bus.WbErr, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    chk("wberr_sticky", bus.WbErr, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 1); cycle();
    drive(1, 2, 64'h22, 0, 0, 0, 0, 0, 2, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0); cycle();
    chk("rst_kill_regwr", bus.RegWr, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1); #2 chk("rst_clear_stall", bus.StallA, 0); cycle();
    a_rd = 0; m_rd = 0; a_d = 0; m_d = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!alu_lost) begin
        a_v = $urandom_range(0, 2) == 0;
        a_rd = 5'($urandom_range(0, 8) == 8 ? 31 : $urandom_range(2, 9));
        a_d = {$urandom, $urandom};
      end
      if (!mem_lost) begin
        m_v = $urandom_range(0, 2) == 0;
        m_rd = 5'($urandom_range(0, 8) == 8 ? 31 : $urandom_range(2, 9));
        m_d = {$urandom, $urandom};
      end
      drive(a_v, int'(a_rd), a_d, m_v, int'(m_rd), m_d, $urandom_range(0, 1) == 1,
            $urandom_range(0, 8) == 8 ? 31 : $urandom_range(2, 9),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 99) != 0);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
